// File: rtl/cp0_unit_pkg.sv
// ============================================================================
//  Module   : cp0_unit_pkg
//  Purpose  : Shared CP0 constants: register indices, exception codes,
//             handler vector and SR/Cause field positions.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package cp0_unit_pkg;

    localparam logic [4:0]  REG_SR        = 5'd12;
    localparam logic [4:0]  REG_CAUSE     = 5'd13;
    localparam logic [4:0]  REG_EPC       = 5'd14;
    localparam logic [4:0]  REG_PRID      = 5'd15;

    localparam logic [4:0]  EXC_INT       = 5'd0;
    localparam logic [4:0]  EXC_ADEL      = 5'd4;
    localparam logic [4:0]  EXC_ADES      = 5'd5;
    localparam logic [4:0]  EXC_SYSCALL   = 5'd8;
    localparam logic [4:0]  EXC_RI        = 5'd10;
    localparam logic [4:0]  EXC_OV        = 5'd12;

    localparam logic [31:0] HANDLER_ADDR  = 32'h0000_4180;

    localparam int          SR_IE         = 0;
    localparam int          SR_EXL        = 1;
    localparam int          SR_IM_LSB     = 10;
    localparam int          CAUSE_EXC_LSB = 2;
    localparam int          CAUSE_IP_LSB  = 10;
    localparam int          CAUSE_BD      = 31;

endpackage

`default_nettype wire

// File: rtl/cp0_unit_if.sv
// ============================================================================
//  Module   : cp0_unit_if
//  Purpose  : M-stage to CP0 signal bundle; the pipeline is master.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface cp0_unit_if;
    logic [4:0]  cp0_addr;
    logic [31:0] cp0_wdata;
    logic        cp0_we;
    logic [31:0] vpc;
    logic        bd_in;
    logic [4:0]  exc_code_in;
    logic        eret_in;
    logic [5:0]  hw_int;
    logic [31:0] cp0_rdata;
    logic [31:0] epc_out;
    logic        req;

    modport master (
        output cp0_addr, cp0_wdata, cp0_we, vpc, bd_in, exc_code_in, eret_in, hw_int,
        input  cp0_rdata, epc_out, req
    );

    modport slave (
        input  cp0_addr, cp0_wdata, cp0_we, vpc, bd_in, exc_code_in, eret_in, hw_int,
        output cp0_rdata, epc_out, req
    );
endinterface

`default_nettype wire

// File: rtl/cp0_unit.sv
// ============================================================================
//  Module   : cp0_unit
//  Purpose  : Coprocessor 0 - SR/Cause/EPC/PRId, exception request, mfc0/mtc0.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module cp0_unit
    import cp0_unit_pkg::*;
#(
    parameter logic [31:0] PRID_VALUE = 32'h0000_2023
) (
    input  wire logic   clk,
    input  wire logic   reset,
    cp0_unit_if.slave   bus
);

    logic [5:0]  r_im;
    logic        r_exl;
    logic        r_ie;
    logic        r_bd;
    logic [5:0]  r_ip;
    logic [4:0]  r_exc_code;
    logic [31:0] r_epc;

    logic        w_int_req;
    logic        w_exc_req;
    logic        w_req;
    logic [31:0] w_sr;
    logic [31:0] w_cause;
    logic [31:0] w_rdata;

    assign w_int_req = (|(bus.hw_int & r_im)) & r_ie & ~r_exl;
    assign w_exc_req = (bus.exc_code_in != EXC_INT) & ~r_exl;
    assign w_req     = w_int_req | w_exc_req;

    assign w_sr    = {16'b0, r_im, 8'b0, r_exl, r_ie};
    assign w_cause = {r_bd, 15'b0, r_ip, 3'b0, r_exc_code, 2'b0};

    always_comb begin
        w_rdata = 32'b0;
        case (bus.cp0_addr)
            REG_SR:    w_rdata = w_sr;
            REG_CAUSE: w_rdata = w_cause;
            REG_EPC:   w_rdata = r_epc;
            REG_PRID:  w_rdata = PRID_VALUE;
            default:   w_rdata = 32'b0;
        endcase
    end

    assign bus.req       = w_req;
    assign bus.cp0_rdata = w_rdata;
    assign bus.epc_out   = r_epc;

    // Exception entry takes precedence over eret and suppresses any mtc0.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_im       <= 6'b0;
            r_exl      <= 1'b0;
            r_ie       <= 1'b0;
            r_bd       <= 1'b0;
            r_ip       <= 6'b0;
            r_exc_code <= 5'b0;
            r_epc      <= 32'b0;
        end else begin
            r_ip <= bus.hw_int;
            if (w_req) begin
                r_exl      <= 1'b1;
                r_bd       <= bus.bd_in;
                r_exc_code <= w_int_req ? EXC_INT : bus.exc_code_in;
                r_epc      <= bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
            end else begin
                if (bus.eret_in) begin
                    r_exl <= 1'b0;
                end
                if (bus.cp0_we) begin
                    case (bus.cp0_addr)
                        REG_SR: begin
                            r_im  <= bus.cp0_wdata[SR_IM_LSB +: 6];
                            r_exl <= bus.cp0_wdata[SR_EXL];
                            r_ie  <= bus.cp0_wdata[SR_IE];
                        end
                        REG_EPC: r_epc <= {bus.cp0_wdata[31:2], 2'b00};
                        default: ;
                    endcase
                end
            end
        end
    end

endmodule

`default_nettype wire
